// File: rtl/bash_hash_params_pkg.sv
// Shared constants and types for the bash_hash sponge and its sequencer.
// Optional permutation counter in bash_hash_ctrl: BASH_HASH_CTRL_PERF_EN.
package bash_hash_params_pkg;

  localparam int XLEN = 2;
  localparam int SLEN = 1536;
  localparam int ROUNDS_DEFAULT = 24;

  localparam logic [XLEN-1:0] L_128 = 2'b01;
  localparam logic [XLEN-1:0] L_192 = 2'b10;
  localparam logic [XLEN-1:0] L_256 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bash_hash_round_cnt.sv
// Step counter for one bash-f permutation: clearable, wraps at
// terminal count ROUNDS-1, which it flags combinationally.
module bash_hash_round_cnt #(
  parameter int ROUNDS = 24,
  parameter int RCW    = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr,
  input  logic           en,
  output logic [RCW-1:0] cnt,
  output logic           tc
);

  assign tc = (cnt == RCW'(ROUNDS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr || (en && tc)) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + RCW'(1);
    end
  end

endmodule

// File: rtl/bash_hash_ctrl.sv
// Sequencer for the single-step bash_hash datapath (one bash-f step/cycle).
// Define BASH_HASH_CTRL_PERF_EN to build the completed-permutation counter.
module bash_hash_ctrl
  import bash_hash_params_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int RCW    = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            blk_valid_i,
  output logic            blk_ready_o,
  input  logic            blk_sop_i,
  input  logic            blk_eop_i,
  input  logic [XLEN-1:0] blk_l_i,
  input  logic            abort_i,
  output logic            prep_o,
  output logic            start_o,
  output logic            work_o,
  output logic            first_o,
  output logic [XLEN-1:0] l_o,
  output logic [RCW-1:0]  round_o,
  output logic            busy_o,
  output logic            hash_valid_o,
  input  logic            hash_ready_i,
  output logic [31:0]     perm_cnt_o
);

  state_e          state_q;
  state_e          state_d;
  logic            sop_q;
  logic            eop_q;
  logic [XLEN-1:0] l_q;
  logic [RCW-1:0]  cnt;
  logic            tc;
  logic            accept;
  logic            in_idle;
  logic            in_run;

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);

  // Gated by rst_ni so every output reads 0 while reset is held.
  assign blk_ready_o = in_idle && !abort_i && rst_ni;
  assign accept      = blk_valid_i && blk_ready_o;

  bash_hash_round_cnt #(
    .ROUNDS (ROUNDS),
    .RCW    (RCW)
  ) u_round_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (state_q == ST_LOAD),
    .en     (in_run),
    .cnt    (cnt),
    .tc     (tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: state_d = abort_i ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort_i) state_d = ST_IDLE;
        else if (tc) state_d = eop_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (abort_i || hash_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sop_q <= blk_sop_i;
        eop_q <= blk_eop_i;
        if (blk_sop_i) l_q <= blk_l_i;
      end
    end
  end

  assign start_o      = (state_q == ST_LOAD);
  assign prep_o       = start_o && sop_q;
  assign work_o       = in_run;
  assign first_o      = in_run && sop_q && (cnt == '0);
  assign round_o      = in_run ? cnt : '0;
  assign l_o          = l_q;
  assign busy_o       = !in_idle;
  assign hash_valid_o = (state_q == ST_DONE);

`ifdef BASH_HASH_CTRL_PERF_EN
  logic [31:0] perm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perm_q <= '0;
    end else if (in_run && tc && (perm_q != 32'hFFFF_FFFF)) begin
      perm_q <= perm_q + 32'd1;
    end
  end

  assign perm_cnt_o = perm_q;
`else
  assign perm_cnt_o = 32'd0;
`endif

endmodule
